lsq_mem_issue: RTL and testbench
================================

Name: lsq_mem_issue

Overview:
- Downstream consumer of the load/store queue.
- Each cycle it scans the LSQ entry vector and picks one memory operation:
  - the committed store at the head, or
  - the oldest load whose older stores are all disambiguated.
- Loads are satisfied by store-to-load forwarding or by a data-memory request/response handshake.
- The completed entry is reported back as done_valid/done_index/done_data; this is the LSQ's memory-stage update (memory_le1 / mem_index1).

Parameters:
- LSQ_SIZE, 8, number of LSQ entries; indices are 1-based (1..LSQ_SIZE), as in the LSQ.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TAG_W, 6, ROB tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  branch-mispredict squash of all uncommitted loads.
- lsq_head  in  int  1-based index of the oldest LSQ entry.
- commit_store  in  1  ROB: the store at lsq_head may write memory.
- entry_valid  in  LSQ_SIZE  entry occupied; bit i-1 is index i.
- entry_is_store  in  LSQ_SIZE  1 = store, 0 = load.
- entry_addr_ready  in  LSQ_SIZE  address computed.
- entry_data_ready  in  LSQ_SIZE  store data available.
- entry_done  in  LSQ_SIZE  memory work already completed.
- entry_addr  in  LSQ_SIZE*ADDR_W  packed addresses.
- entry_data  in  LSQ_SIZE*DATA_W  packed store data.
- entry_tag  in  LSQ_SIZE*TAG_W  packed ROB tags.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_write  out  1  1 = store.
- mem_req_addr  out  ADDR_W  request address.
- mem_req_wdata  out  DATA_W  store data.
- mem_resp_valid  in  1  load data returned (stores get no response).
- mem_resp_rdata  in  DATA_W  load data.
- done_valid  out  1  one-cycle completion pulse.
- done_index  out  int  1-based LSQ index completed.
- done_data  out  DATA_W  load result (0 for stores).
- done_tag  out  TAG_W  ROB tag of completed entry.
- store_retired  out  1  pulse when a store is accepted by memory; drives lsq_decrement.

Behaviour:
- Reset: state = IDLE. mem_req_valid, mem_req_write, done_valid, store_retired and drop_pending = 0. mem_req_addr, mem_req_wdata, done_data, done_tag = 0. done_index = 0.
- Age: age(i) = (i - lsq_head + LSQ_SIZE) % LSQ_SIZE; 0 is the oldest entry.
- Selection runs in IDLE only. Store priority:
  - If the head entry is a valid, not-done store with commit_store, addr_ready and data_ready, issue it.
  - Otherwise take the oldest valid, not-done, addr_ready load such that every valid older store has addr_ready.
- Forwarding check for the chosen load: find the youngest older store with the same address.
  - Match with data_ready: forward.
  - Match without data_ready: the load is not eligible this cycle; no younger load bypasses it.
- The index reported on done in the previous cycle is masked from selection for one cycle; this covers the LSQ register latency.
- States:
  - IDLE -> DONE: forwarded load. Load latency is 1 cycle.
  - IDLE -> REQ: memory load or store. Request fields are registered and mem_req_valid = 1 in REQ.
  - REQ: fields are held stable while mem_req_valid && !mem_req_ready. On acceptance:
    - Store: pulse store_retired and go to DONE.
    - Load: go to WAIT.
  - WAIT: on mem_resp_valid, capture rdata and go to DONE. If drop_pending is set, clear it and go to IDLE with no done pulse.
  - DONE: done_valid = 1 for exactly one cycle with the latched index, tag and data, then IDLE.
- Flush:
  - A load in REQ or DONE returns to IDLE; a REQ load's request is withdrawn.
  - A load in WAIT sets drop_pending; the late response is consumed silently.
  - Store operations in any state are unaffected (already committed).
  - Flush in IDLE blocks selection for that cycle.
- Reset mid-operation discards everything, including an in-flight response.
- Index wrap: LSQ_SIZE wraps to 1. Ordering across the wrap is by age(), not raw index.
- Empty (no valid entries) or no eligible entry: remain in IDLE, outputs idle.
- At most one outstanding memory operation.

Test Plan:
- Forwarding: head = 3. Index 3 is a store, addr 0x100, data 0xDEAD, ready, not committed. Index 4 is a load, addr 0x100 -> no mem request; next cycle done_valid = 1, done_index = 4, done_data = 0xDEAD.
- Memory load: the only entry is index 1, a load at 0x40. mem_req_ready stalls 2 cycles, then response 0x1234 arrives 3 cycles later -> mem_req_addr stays 0x40 throughout the stall; done_index = 1, done_data = 0x1234 the cycle after the response.
- Disambiguation stall: head = 2. Index 2 is a store with addr not ready; index 3 is a load -> no issue. Store address becomes 0x80 (load 0x90) -> the load issues to memory the next cycle.
- Wrap-around ordering: LSQ_SIZE = 8, head = 7. Store at index 8 has addr 0x20, data 5; load at index 1 has addr 0x20 -> forwarding from index 8, done_data = 5.
- Committed store: head store at 0x10, data 9, commit_store = 1, mem_req_ready = 1 -> mem_req_write = 1; store_retired and done_valid pulse once; no response awaited.
- Flush in WAIT: load outstanding, flush = 1, response arrives 2 cycles later -> no done_valid; next eligible entry issues normally.

Source files
------------

// File: rtl/lsq_mem_issue_if.sv
// Memory request/response channel between the LSQ issue stage and the data memory.
// At most one request is outstanding; stores get no response.
interface lsq_mem_issue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_write;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_rdata;

  modport master (
    output mem_req_valid,
    output mem_req_write,
    output mem_req_addr,
    output mem_req_wdata,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_rdata
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_write,
    input  mem_req_addr,
    input  mem_req_wdata,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_rdata
  );
endinterface

// File: rtl/lsq_mem_issue.sv
// LSQ memory-stage issue unit: picks the committed head store or the oldest disambiguated
// load, satisfies loads by forwarding or a memory round trip, and reports completion.
//
// state  | meaning
// S_IDLE | scanning the LSQ for an eligible store or load
// S_REQ  | request registered on the memory bus, waiting for acceptance
// S_WAIT | load accepted by memory, waiting for its response
// S_DONE | one-cycle completion pulse back to the LSQ
module lsq_mem_issue #(
  parameter  int LSQ_SIZE = 8,
  parameter  int ADDR_W   = 32,
  parameter  int DATA_W   = 32,
  parameter  int TAG_W    = 6,
  localparam int IDX_W    = $clog2(LSQ_SIZE + 1),
  localparam int POS_W    = (LSQ_SIZE > 1) ? $clog2(LSQ_SIZE) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_flush,
  input  logic [IDX_W-1:0]           i_lsq_head,
  input  logic                       i_commit_store,
  input  logic [LSQ_SIZE-1:0]        i_entry_valid,
  input  logic [LSQ_SIZE-1:0]        i_entry_is_store,
  input  logic [LSQ_SIZE-1:0]        i_entry_addr_ready,
  input  logic [LSQ_SIZE-1:0]        i_entry_data_ready,
  input  logic [LSQ_SIZE-1:0]        i_entry_done,
  input  logic [LSQ_SIZE*ADDR_W-1:0] i_entry_addr,
  input  logic [LSQ_SIZE*DATA_W-1:0] i_entry_data,
  input  logic [LSQ_SIZE*TAG_W-1:0]  i_entry_tag,
  lsq_mem_issue_if.master            mem_bus,
  output logic                       o_done_valid,
  output logic [IDX_W-1:0]           o_done_index,
  output logic [DATA_W-1:0]          o_done_data,
  output logic [TAG_W-1:0]           o_done_tag,
  output logic                       o_store_retired
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              r_state;
  logic                r_req_valid;
  logic                r_req_write;
  logic [ADDR_W-1:0]   r_req_addr;
  logic [DATA_W-1:0]   r_req_wdata;
  logic                r_done_valid;
  logic [IDX_W-1:0]    r_done_index;
  logic [DATA_W-1:0]   r_done_data;
  logic [TAG_W-1:0]    r_done_tag;
  logic                r_store_retired;
  logic                r_drop_pending;
  logic                r_op_is_store;
  logic                r_mask_valid;
  logic [IDX_W-1:0]    r_mask_index;

  logic [ADDR_W-1:0]   w_addr [LSQ_SIZE];
  logic [DATA_W-1:0]   w_data [LSQ_SIZE];
  logic [TAG_W-1:0]    w_tag  [LSQ_SIZE];
  logic [LSQ_SIZE-1:0] w_masked;

  logic                w_sel_valid;
  logic                w_sel_store;
  logic                w_sel_fwd;
  logic [POS_W-1:0]    w_sel_pos;
  logic [DATA_W-1:0]   w_fwd_data;

  // The LSQ sees our done pulse one cycle late, so the just-completed entry is hidden for a cycle.
  for (genvar g = 0; g < LSQ_SIZE; g++) begin : g_unpack
    assign w_addr[g]   = i_entry_addr[g*ADDR_W +: ADDR_W];
    assign w_data[g]   = i_entry_data[g*DATA_W +: DATA_W];
    assign w_tag[g]    = i_entry_tag[g*TAG_W +: TAG_W];
    assign w_masked[g] = r_mask_valid && (r_mask_index == IDX_W'(g + 1));
  end

  always_comb begin
    logic [POS_W-1:0]  hp;
    logic [POS_W-1:0]  p;
    logic [POS_W-1:0]  q;
    logic              blocked;
    logic              match;
    logic              match_rdy;
    logic [DATA_W-1:0] match_data;

    w_sel_valid = 1'b0;
    w_sel_store = 1'b0;
    w_sel_fwd   = 1'b0;
    w_sel_pos   = '0;
    w_fwd_data  = '0;
    hp          = POS_W'(i_lsq_head - IDX_W'(1));
    p           = '0;
    q           = '0;
    blocked     = 1'b0;
    match       = 1'b0;
    match_rdy   = 1'b0;
    match_data  = '0;

    if (i_entry_valid[hp] && i_entry_is_store[hp] && !i_entry_done[hp] && i_commit_store &&
        i_entry_addr_ready[hp] && i_entry_data_ready[hp] && !w_masked[hp]) begin
      w_sel_valid = 1'b1;
      w_sel_store = 1'b1;
      w_sel_pos   = hp;
    end else begin
      // Walk oldest to youngest; an unresolved older store or a pending forward stops the walk.
      for (int a = 0; a < LSQ_SIZE; a++) begin
        p = POS_W'((int'(hp) + a) % LSQ_SIZE);
        if (i_entry_valid[p] && !w_sel_valid && !blocked) begin
          if (i_entry_is_store[p]) begin
            if (!i_entry_addr_ready[p]) blocked = 1'b1;
          end else if (!i_entry_done[p] && i_entry_addr_ready[p] && !w_masked[p]) begin
            match      = 1'b0;
            match_rdy  = 1'b0;
            match_data = '0;
            for (int b = 0; b < LSQ_SIZE; b++) begin
              q = POS_W'((int'(hp) + b) % LSQ_SIZE);
              if ((b < a) && i_entry_valid[q] && i_entry_is_store[q] &&
                  (w_addr[q] == w_addr[p])) begin
                match      = 1'b1;
                match_rdy  = i_entry_data_ready[q];
                match_data = w_data[q];
              end
            end
            if (match && !match_rdy) begin
              blocked = 1'b1;
            end else begin
              w_sel_valid = 1'b1;
              w_sel_fwd   = match;
              w_sel_pos   = p;
              w_fwd_data  = match_data;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state         <= S_IDLE;
      r_req_valid     <= 1'b0;
      r_req_write     <= 1'b0;
      r_req_addr      <= '0;
      r_req_wdata     <= '0;
      r_done_valid    <= 1'b0;
      r_done_index    <= '0;
      r_done_data     <= '0;
      r_done_tag      <= '0;
      r_store_retired <= 1'b0;
      r_drop_pending  <= 1'b0;
      r_op_is_store   <= 1'b0;
      r_mask_valid    <= 1'b0;
      r_mask_index    <= '0;
    end else begin
      r_done_valid    <= 1'b0;
      r_store_retired <= 1'b0;
      r_mask_valid    <= r_done_valid;
      r_mask_index    <= r_done_index;
      case (r_state)
        S_IDLE: begin
          if (!i_flush && w_sel_valid) begin
            r_done_index  <= IDX_W'(w_sel_pos) + IDX_W'(1);
            r_done_tag    <= w_tag[w_sel_pos];
            r_op_is_store <= w_sel_store;
            if (w_sel_fwd) begin
              r_done_data  <= w_fwd_data;
              r_done_valid <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_done_data <= '0;
              r_req_valid <= 1'b1;
              r_req_write <= w_sel_store;
              r_req_addr  <= w_addr[w_sel_pos];
              r_req_wdata <= w_sel_store ? w_data[w_sel_pos] : '0;
              r_state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_bus.mem_req_ready) begin
            r_req_valid <= 1'b0;
            if (r_op_is_store) begin
              r_store_retired <= 1'b1;
              r_done_valid    <= 1'b1;
              r_state         <= S_DONE;
            end else begin
              // Accepted in the flush cycle: a response is still coming and must be eaten.
              r_drop_pending <= i_flush;
              r_state        <= S_WAIT;
            end
          end else if (i_flush && !r_op_is_store) begin
            r_req_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (mem_bus.mem_resp_valid) begin
            if (r_drop_pending || i_flush) begin
              r_drop_pending <= 1'b0;
              r_state        <= S_IDLE;
            end else begin
              r_done_data  <= mem_bus.mem_resp_rdata;
              r_done_valid <= 1'b1;
              r_state      <= S_DONE;
            end
          end else if (i_flush) begin
            r_drop_pending <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_bus.mem_req_valid = r_req_valid;
  assign mem_bus.mem_req_write = r_req_write;
  assign mem_bus.mem_req_addr  = r_req_addr;
  assign mem_bus.mem_req_wdata = r_req_wdata;

  assign o_done_valid    = r_done_valid;
  assign o_done_index    = r_done_index;
  assign o_done_data     = r_done_data;
  assign o_done_tag      = r_done_tag;
  assign o_store_retired = r_store_retired;

endmodule

// File: tb/tb_lsq_mem_issue.sv
// Directed bench for lsq_mem_issue: each task sets up LSQ contents and compares outputs
// against hand-computed values one cycle at a time.
module tb_lsq_mem_issue;
  localparam int N  = 8;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TW = 6;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic [IW-1:0]   lsq_head;
  logic            commit_store;
  logic [N-1:0]    entry_valid;
  logic [N-1:0]    entry_is_store;
  logic [N-1:0]    entry_addr_ready;
  logic [N-1:0]    entry_data_ready;
  logic [N-1:0]    entry_done;
  logic [N*AW-1:0] entry_addr;
  logic [N*DW-1:0] entry_data;
  logic [N*TW-1:0] entry_tag;
  logic            done_valid;
  logic [IW-1:0]   done_index;
  logic [DW-1:0]   done_data;
  logic [TW-1:0]   done_tag;
  logic            store_retired;

  int n_checks = 0;
  int n_errors = 0;

  lsq_mem_issue_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  lsq_mem_issue #(.LSQ_SIZE(N), .ADDR_W(AW), .DATA_W(DW), .TAG_W(TW)) dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_flush            (flush),
    .i_lsq_head         (lsq_head),
    .i_commit_store     (commit_store),
    .i_entry_valid      (entry_valid),
    .i_entry_is_store   (entry_is_store),
    .i_entry_addr_ready (entry_addr_ready),
    .i_entry_data_ready (entry_data_ready),
    .i_entry_done       (entry_done),
    .i_entry_addr       (entry_addr),
    .i_entry_data       (entry_data),
    .i_entry_tag        (entry_tag),
    .mem_bus            (mif),
    .o_done_valid       (done_valid),
    .o_done_index       (done_index),
    .o_done_data        (done_data),
    .o_done_tag         (done_tag),
    .o_store_retired    (store_retired)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_entries();
    entry_valid      = '0;
    entry_is_store   = '0;
    entry_addr_ready = '0;
    entry_data_ready = '0;
    entry_done       = '0;
    entry_addr       = '0;
    entry_data       = '0;
    entry_tag        = '0;
  endtask

  task automatic set_entry(input int idx, input bit st, input bit ar, input bit dr,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [TW-1:0] tag);
    entry_valid[idx-1]           = 1'b1;
    entry_is_store[idx-1]        = st;
    entry_addr_ready[idx-1]      = ar;
    entry_data_ready[idx-1]      = dr;
    entry_done[idx-1]            = 1'b0;
    entry_addr[(idx-1)*AW +: AW] = addr;
    entry_data[(idx-1)*DW +: DW] = data;
    entry_tag[(idx-1)*TW +: TW]  = tag;
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    flush              = 1'b0;
    commit_store       = 1'b0;
    lsq_head           = 4'd1;
    mif.mem_req_ready  = 1'b0;
    mif.mem_resp_valid = 1'b0;
    mif.mem_resp_rdata = '0;
    clear_entries();
    tick(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    set_entry(1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 6'd1);
    tick(2);
    n_checks++; if (mif.mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL reset_req_valid: got %b want 0", mif.mem_req_valid); end
    n_checks++; if (done_valid !== 1'b0) begin n_errors++; $display("FAIL reset_done_valid: got %b want 0", done_valid); end
    n_checks++; if (store_retired !== 1'b0) begin n_errors++; $display("FAIL reset_store_retired: got %b want 0", store_retired); end
    n_checks++; if (done_index !== 4'd0) begin n_errors++; $display("FAIL reset_done_index: got %0d want 0", done_index); end
    n_checks++; if (mif.mem_req_addr !== 32'h0) begin n_errors++; $display("FAIL reset_req_addr: got %h want 0", mif.mem_req_addr); end
    n_checks++; if (done_data !== 32'h0) begin n_errors++; $display("FAIL reset_done_data: got %h want 0", done_data); end
    reset = 1'b0;
    clear_entries();
    tick(3);
    n_checks++; if (mif.mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL empty_req_valid: got %b want 0", mif.mem_req_valid); end
    n_checks++; if (done_valid !== 1'b0) begin n_errors++; $display("FAIL empty_done_valid: got %b want 0", done_valid); end
  endtask

  task automatic test_forwarding();
    do_reset();
    lsq_head = 4'd3;
    set_entry(3, 1'b1, 1'b1, 1'b1, 32'h100, 32'hDEAD, 6'd3);
    set_entry(4, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0,    6'd4);
    tick();
    n_checks++; if (mif.mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL fwd_no_req: got %b want 0", mif.mem_req_valid); end
    n_checks++; if (done_valid !== 1'b1) begin n_errors++; $display("FAIL fwd_done_valid: got %b want 1", done_valid); end
    n_checks++; if (done_index !== 4'd4) begin n_errors++; $display("FAIL fwd_done_index: got %0d want 4", done_index); end
    n_checks++; if (done_data !== 32'hDEAD) begin n_errors++; $display("FAIL fwd_done_data: got %h want dead", done_data); end
    n_checks++; if (done_tag !== 6'd4) begin n_errors++; $display("FAIL fwd_done_tag: got %0d want 4", done_tag); end
    tick();
    n_checks++; if (done_valid !== 1'b0) begin n_errors++; $display("FAIL fwd_pulse_len: got %b want 0", done_valid); end
    tick();
    n_checks++; if (done_valid !== 1'b0) begin n_errors++; $display("FAIL fwd_masked: got %b want 0", done_valid); end
    entry_done[3] = 1'b1;
    tick();
    n_checks++; if (done_valid !== 1'b0) begin n_errors++; $display("FAIL fwd_no_repeat: got %b want 0", done_valid); end
  endtask

  task automatic test_mem_load();
    do_reset();
    lsq_head = 4'd1;
    set_entry(1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 6'd11);
    tick();
    n_checks++; if (mif.mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL ld_req_valid: got %b want 1", mif.mem_req_valid); end
    n_checks++; if (mif.mem_req_write !== 1'b0) begin n_errors++; $display("FAIL ld_req_write: got %b want 0", mif.mem_req_write); end
    n_checks++; if (mif.mem_req_addr !== 32'h40) begin n_errors++; $display("FAIL ld_req_addr: got %h want 40", mif.mem_req_addr); end
    tick();
    n_checks++; if (mif.mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL ld_stall_valid: got %b want 1", mif.mem_req_valid); end
    n_checks++; if (mif.mem_req_addr !== 32'h40) begin n_errors++; $display("FAIL ld_stall_addr: got %h want 40", mif.mem_req_addr); end
    mif.mem_req_ready = 1'b1;
    tick();
    mif.mem_req_ready = 1'b0;
    n_checks++; if (mif.mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL ld_accepted: got %b want 0", mif.mem_req_valid); end
    tick(2);
    n_checks++; if (done_valid !== 1'b0) begin n_errors++; $display("FAIL ld_wait_done: got %b want 0", done_valid); end
    mif.mem_resp_valid = 1'b1;
    mif.mem_resp_rdata = 32'h1234;
    tick();
    mif.mem_resp_valid = 1'b0;
    n_checks++; if (done_valid !== 1'b1) begin n_errors++; $display("FAIL ld_done_valid: got %b want 1", done_valid); end
    n_checks++; if (done_index !== 4'd1) begin n_errors++; $display("FAIL ld_done_index: got %0d want 1", done_index); end
    n_checks++; if (done_data !== 32'h1234) begin n_errors++; $display("FAIL ld_done_data: got %h want 1234", done_data); end
    n_checks++; if (done_tag !== 6'd11) begin n_errors++; $display("FAIL ld_done_tag: got %0d want 11", done_tag); end
    entry_done[0] = 1'b1;
    tick();
    n_checks++; if (done_valid !== 1'b0) begin n_errors++; $display("FAIL ld_pulse_len: got %b want 0", done_valid); end
  endtask

  task automatic test_disambiguation();
    logic [AW-1:0] st_addr;
    do_reset();
    lsq_head = 4'd2;
    set_entry(2, 1'b1, 1'b0, 1'b1, 32'h0,  32'h7, 6'd2);
    set_entry(3, 1'b0, 1'b1, 1'b0, 32'h90, 32'h0, 6'd3);
    tick(2);
    n_checks++; if (mif.mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL dis_stall_req: got %b want 0", mif.mem_req_valid); end
    n_checks++; if (done_valid !== 1'b0) begin n_errors++; $display("FAIL dis_stall_done: got %b want 0", done_valid); end
    st_addr = 32'h80;
    entry_addr[1*AW +: AW] = st_addr;
    entry_addr_ready[1]    = 1'b1;
    tick();
    n_checks++; if (mif.mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL dis_issue_valid: got %b want 1", mif.mem_req_valid); end
    n_checks++; if (mif.mem_req_addr !== 32'h90) begin n_errors++; $display("FAIL dis_issue_addr: got %h want 90", mif.mem_req_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    lsq_head = 4'd7;
    set_entry(7, 1'b1, 1'b1, 1'b1, 32'h20, 32'h3,  6'd7);
    set_entry(8, 1'b1, 1'b1, 1'b1, 32'h20, 32'h5,  6'd8);
    set_entry(1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0,  6'd1);
    set_entry(2, 1'b1, 1'b1, 1'b1, 32'h20, 32'h77, 6'd2);
    tick();
    n_checks++; if (mif.mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL wrap_no_req: got %b want 0", mif.mem_req_valid); end
    n_checks++; if (done_valid !== 1'b1) begin n_errors++; $display("FAIL wrap_done_valid: got %b want 1", done_valid); end
    n_checks++; if (done_index !== 4'd1) begin n_errors++; $display("FAIL wrap_done_index: got %0d want 1", done_index); end
    n_checks++; if (done_data !== 32'h5) begin n_errors++; $display("FAIL wrap_done_data: got %h want 5", done_data); end
  endtask

  task automatic test_committed_store();
    do_reset();
    lsq_head = 4'd1;
    set_entry(1, 1'b1, 1'b1, 1'b1, 32'h10, 32'h9, 6'd5);
    commit_store      = 1'b1;
    mif.mem_req_ready = 1'b1;
    tick();
    n_checks++; if (mif.mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL st_req_valid: got %b want 1", mif.mem_req_valid); end
    n_checks++; if (mif.mem_req_write !== 1'b1) begin n_errors++; $display("FAIL st_req_write: got %b want 1", mif.mem_req_write); end
    n_checks++; if (mif.mem_req_addr !== 32'h10) begin n_errors++; $display("FAIL st_req_addr: got %h want 10", mif.mem_req_addr); end
    n_checks++; if (mif.mem_req_wdata !== 32'h9) begin n_errors++; $display("FAIL st_req_wdata: got %h want 9", mif.mem_req_wdata); end
    n_checks++; if (store_retired !== 1'b0) begin n_errors++; $display("FAIL st_early_retire: got %b want 0", store_retired); end
    tick();
    n_checks++; if (store_retired !== 1'b1) begin n_errors++; $display("FAIL st_retired: got %b want 1", store_retired); end
    n_checks++; if (done_valid !== 1'b1) begin n_errors++; $display("FAIL st_done_valid: got %b want 1", done_valid); end
    n_checks++; if (done_index !== 4'd1) begin n_errors++; $display("FAIL st_done_index: got %0d want 1", done_index); end
    n_checks++; if (done_data !== 32'h0) begin n_errors++; $display("FAIL st_done_data: got %h want 0", done_data); end
    n_checks++; if (mif.mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL st_req_drop: got %b want 0", mif.mem_req_valid); end
    commit_store      = 1'b0;
    entry_valid[0]    = 1'b0;
    lsq_head          = 4'd2;
    set_entry(2, 1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 6'd6);
    mif.mem_req_ready = 1'b0;
    tick();
    n_checks++; if (store_retired !== 1'b0) begin n_errors++; $display("FAIL st_retire_len: got %b want 0", store_retired); end
    n_checks++; if (done_valid !== 1'b0) begin n_errors++; $display("FAIL st_done_len: got %b want 0", done_valid); end
    tick();
    n_checks++; if (mif.mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL st_next_valid: got %b want 1", mif.mem_req_valid); end
    n_checks++; if (mif.mem_req_addr !== 32'h44) begin n_errors++; $display("FAIL st_next_addr: got %h want 44", mif.mem_req_addr); end
  endtask

  task automatic test_flush_req();
    do_reset();
    lsq_head = 4'd1;
    set_entry(1, 1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 6'd1);
    tick();
    n_checks++; if (mif.mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL fr_req_valid: got %b want 1", mif.mem_req_valid); end
    flush = 1'b1;
    tick();
    n_checks++; if (mif.mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL fr_withdrawn: got %b want 0", mif.mem_req_valid); end
    tick();
    n_checks++; if (mif.mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL fr_idle_block: got %b want 0", mif.mem_req_valid); end
    flush = 1'b0;
    tick();
    n_checks++; if (mif.mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL fr_reissue: got %b want 1", mif.mem_req_valid); end
    n_checks++; if (mif.mem_req_addr !== 32'h30) begin n_errors++; $display("FAIL fr_reissue_addr: got %h want 30", mif.mem_req_addr); end
  endtask

  task automatic test_flush_wait();
    do_reset();
    lsq_head = 4'd1;
    set_entry(1, 1'b0, 1'b1, 1'b0, 32'h60, 32'h0, 6'd1);
    set_entry(2, 1'b0, 1'b1, 1'b0, 32'h64, 32'h0, 6'd2);
    mif.mem_req_ready = 1'b1;
    tick();
    n_checks++; if (mif.mem_req_addr !== 32'h60) begin n_errors++; $display("FAIL fw_oldest_addr: got %h want 60", mif.mem_req_addr); end
    tick();
    n_checks++; if (mif.mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL fw_in_wait: got %b want 0", mif.mem_req_valid); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clear_entries();
    lsq_head = 4'd3;
    set_entry(3, 1'b0, 1'b1, 1'b0, 32'h70, 32'h0, 6'd3);
    tick();
    mif.mem_resp_valid = 1'b1;
    mif.mem_resp_rdata = 32'hBAD;
    tick();
    mif.mem_resp_valid = 1'b0;
    n_checks++; if (done_valid !== 1'b0) begin n_errors++; $display("FAIL fw_dropped: got %b want 0", done_valid); end
    n_checks++; if (mif.mem_req_valid !== 1'b0) begin n_errors++; $display("FAIL fw_drop_idle: got %b want 0", mif.mem_req_valid); end
    tick();
    n_checks++; if (mif.mem_req_valid !== 1'b1) begin n_errors++; $display("FAIL fw_next_valid: got %b want 1", mif.mem_req_valid); end
    n_checks++; if (mif.mem_req_addr !== 32'h70) begin n_errors++; $display("FAIL fw_next_addr: got %h want 70", mif.mem_req_addr); end
    n_checks++; if (done_valid !== 1'b0) begin n_errors++; $display("FAIL fw_late_done: got %b want 0", done_valid); end
    tick();
    mif.mem_resp_valid = 1'b1;
    mif.mem_resp_rdata = 32'h3333;
    tick();
    mif.mem_resp_valid = 1'b0;
    n_checks++; if (done_valid !== 1'b1) begin n_errors++; $display("FAIL fw_next_done: got %b want 1", done_valid); end
    n_checks++; if (done_index !== 4'd3) begin n_errors++; $display("FAIL fw_next_index: got %0d want 3", done_index); end
    n_checks++; if (done_data !== 32'h3333) begin n_errors++; $display("FAIL fw_next_data: got %h want 3333", done_data); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    lsq_head = 4'd1;
    set_entry(1, 1'b0, 1'b1, 1'b0, 32'h50, 32'h0, 6'd1);
    mif.mem_req_ready = 1'b1;
    tick(2);
    reset = 1'b1;
    clear_entries();
    tick();
    reset = 1'b0;
    mif.mem_resp_valid = 1'b1;
    mif.mem_resp_rdata = 32'hAAAA;
    tick();
    mif.mem_resp_valid = 1'b0;
    n_checks++; if (done_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_done: got %b want 0", done_valid); end
    n_checks++; if (done_data !== 32'h0) begin n_errors++; $display("FAIL rst_mid_data: got %h want 0", done_data); end
    tick();
    n_checks++; if (done_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_late: got %b want 0", done_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_forwarding();
    test_mem_load();
    test_disambiguation();
    test_wrap();
    test_committed_store();
    test_flush_req();
    test_flush_wait();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
